// File: rtl/cpu_pkg.sv
// Shared opcode and state encodings plus instruction field positions
// for the multicycle_cpu core.
package cpu_pkg;

    localparam int IMM_W  = 8;
    localparam int OP_HI  = 15;
    localparam int OP_LO  = 12;
    localparam int RS1_HI = 10;
    localparam int RS1_LO = 8;
    localparam int RS2_HI = 7;
    localparam int RS2_LO = 5;
    localparam int RD_HI  = 4;
    localparam int RD_LO  = 2;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_XOR  = 4'h5,
        OP_LDI  = 4'h6,
        OP_LD   = 4'h7,
        OP_ST   = 4'h8,
        OP_JMP  = 4'h9,
        OP_BEQZ = 4'hA,
        OP_HALT = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    // Opcodes 0xB..0xE are undefined; they are reported and then behave as NOP.
    function automatic logic op_is_legal(input logic [3:0] op);
        logic legal;
        case (op)
            4'hB, 4'hC, 4'hD, 4'hE: legal = 1'b0;
            default:                legal = 1'b1;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/cpu_regfile.sv
// Register file: NUM_REGS x DATA_W, two asynchronous read ports and one
// synchronous write port, cleared by the asynchronous reset.
module cpu_regfile #(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [2:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [2:0]        raddr_a,
    input  logic [2:0]        raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] regs_r [NUM_REGS];

    // Register storage with write port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= '0;
            end
        end else if (we) begin
            regs_r[waddr] <= wdata;
        end
    end

    assign rdata_a = regs_r[raddr_a];
    assign rdata_b = regs_r[raddr_b];

endmodule

// File: rtl/multicycle_cpu.sv
// Multi-cycle CPU core: FETCH/DECODE/EXEC/MEM/WB sequencing with req/ack
// instruction and data memory handshakes, carry flag and halt support.
module multicycle_cpu
    import cpu_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter int NUM_REGS = 8
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_rdata,
    input  logic              imem_ack,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              carry_flag,
    output logic              retire,
    output logic              illegal_op,
    output logic              halted,
    output logic [ADDR_W-1:0] dbg_pc
);

    state_e            state_r, state_s;
    logic [15:0]       ir_r;
    logic [DATA_W-1:0] a_r, b_r, res_r;
    logic [ADDR_W-1:0] pc_r, npc_r, npc_s;
    logic              cout_r, carry_r, illegal_r;

    logic [3:0]        op_s;
    logic [2:0]        rs1_s, rs2_s, rd_s, rf_waddr_s;
    logic [IMM_W-1:0]  imm_s;
    logic [DATA_W-1:0] rf_a_s, rf_b_s, alu_s;
    logic [DATA_W:0]   sum_s, diff_s;
    logic              alu_c_s, rf_we_s, unused_s;

    assign op_s     = ir_r[OP_HI:OP_LO];
    assign rs1_s    = ir_r[RS1_HI:RS1_LO];
    assign rs2_s    = ir_r[RS2_HI:RS2_LO];
    assign rd_s     = ir_r[RD_HI:RD_LO];
    assign imm_s    = ir_r[IMM_W-1:0];
    assign unused_s = ^{ir_r[11], ir_r[1:0]};

    cpu_regfile #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .we      (rf_we_s),
        .waddr   (rf_waddr_s),
        .wdata   (res_r),
        .raddr_a (rs1_s),
        .raddr_b (rs2_s),
        .rdata_a (rf_a_s),
        .rdata_b (rf_b_s)
    );

    // ALU; the extra top bit of the SUB difference is the unsigned borrow
    always_comb begin
        sum_s   = {1'b0, a_r} + {1'b0, b_r};
        diff_s  = {1'b0, a_r} - {1'b0, b_r};
        alu_s   = '0;
        alu_c_s = 1'b0;
        case (op_s)
            OP_ADD:  begin alu_s = sum_s[DATA_W-1:0];  alu_c_s = sum_s[DATA_W];  end
            OP_SUB:  begin alu_s = diff_s[DATA_W-1:0]; alu_c_s = diff_s[DATA_W]; end
            OP_AND:  alu_s = a_r & b_r;
            OP_OR:   alu_s = a_r | b_r;
            OP_XOR:  alu_s = a_r ^ b_r;
            OP_LDI:  alu_s = DATA_W'(imm_s);
            default: alu_s = '0;
        endcase
    end

    // Next-PC selection
    always_comb begin
        npc_s = pc_r + ADDR_W'(1'b1);
        if (op_s == OP_JMP) begin
            npc_s = ADDR_W'(imm_s);
        end else if ((op_s == OP_BEQZ) && (a_r == '0)) begin
            npc_s = ADDR_W'(imm_s);
        end else begin
            npc_s = pc_r + ADDR_W'(1'b1);
        end
    end

    // Register write-back control; LDI targets the rs1 field
    always_comb begin
        rf_we_s    = 1'b0;
        rf_waddr_s = rd_s;
        if (state_r == ST_WB) begin
            case (op_s)
                OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LD: rf_we_s = 1'b1;
                OP_LDI:  begin rf_we_s = 1'b1; rf_waddr_s = rs1_s; end
                default: rf_we_s = 1'b0;
            endcase
        end else begin
            rf_we_s = 1'b0;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_FETCH:  if (imem_ack) state_s = ST_DECODE; else state_s = ST_FETCH;
            ST_DECODE: state_s = ST_EXEC;
            ST_EXEC: begin
                case (op_s)
                    OP_LD, OP_ST: state_s = ST_MEM;
                    OP_HALT:      state_s = ST_HALT;
                    default:      state_s = ST_WB;
                endcase
            end
            ST_MEM:    if (dmem_ack) state_s = ST_WB; else state_s = ST_MEM;
            ST_WB:     state_s = ST_FETCH;
            ST_HALT:   state_s = ST_HALT;
            default:   state_s = ST_FETCH;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath registers advanced per FSM phase
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_r      <= 16'h0000;
            a_r       <= '0;
            b_r       <= '0;
            res_r     <= '0;
            pc_r      <= '0;
            npc_r     <= '0;
            cout_r    <= 1'b0;
            carry_r   <= 1'b0;
            illegal_r <= 1'b0;
        end else begin
            illegal_r <= 1'b0;
            case (state_r)
                ST_FETCH:  if (imem_ack) ir_r <= imem_rdata;
                ST_DECODE: begin
                    a_r       <= rf_a_s;
                    b_r       <= rf_b_s;
                    illegal_r <= !op_is_legal(op_s);
                end
                ST_EXEC: begin
                    res_r  <= alu_s;
                    cout_r <= alu_c_s;
                    npc_r  <= npc_s;
                end
                ST_MEM:    if (dmem_ack && (op_s == OP_LD)) res_r <= dmem_rdata;
                ST_WB: begin
                    pc_r <= npc_r;
                    if ((op_s == OP_ADD) || (op_s == OP_SUB)) carry_r <= cout_r;
                end
                default: ;
            endcase
        end
    end

    // The FETCH state is the reset state, so the fetch request is masked by reset
    assign imem_req   = (state_r == ST_FETCH) && !reset;
    assign imem_addr  = pc_r;
    assign dmem_req   = (state_r == ST_MEM);
    assign dmem_we    = (state_r == ST_MEM) && (op_s == OP_ST);
    assign dmem_addr  = ADDR_W'(a_r);
    assign dmem_wdata = b_r;
    assign carry_flag = carry_r;
    assign retire     = (state_r == ST_WB);
    assign illegal_op = illegal_r;
    assign halted     = (state_r == ST_HALT);
    assign dbg_pc     = pc_r;

endmodule

// File: tb/tb_multicycle_cpu.sv
// Scoreboard bench for multicycle_cpu: an ISA-level model predicts each
// retirement; a monitor compares PC, carry, stores and handshake behaviour.
module tb_multicycle_cpu;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack;
    logic [7:0]  imem_addr, dmem_addr, dmem_wdata, dmem_rdata, dbg_pc;
    logic [15:0] imem_rdata;
    logic        carry_flag, retire, illegal_op, halted;

    always #5 clk = ~clk;

    multicycle_cpu #(.DATA_W(8), .ADDR_W(8), .NUM_REGS(8)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .carry_flag(carry_flag), .retire(retire), .illegal_op(illegal_op),
        .halted(halted), .dbg_pc(dbg_pc)
    );

    typedef struct {
        int pc; int npc; int carry; int ill; int st; int addr; int data; int cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] imem [256];
    logic [7:0]  dmem [256];
    logic [7:0]  init_mem [256];
    int vectors = 0, miscompares = 0;
    int rand_mode = 0, iwait = 0, dwait = 0, lat_chk = 0;
    int icnt, itgt, dcnt, dtgt, cyc;
    logic ispur, dspur;

    assign imem_rdata = imem[imem_addr];
    assign dmem_rdata = dmem[dmem_addr];
    assign imem_ack   = imem_req ? (icnt >= itgt) : ispur;
    assign dmem_ack   = dmem_req ? (dcnt >= dtgt) : dspur;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic logic [15:0] enc(input int op, input int rs1, input int rs2, input int rd);
        return {4'(op), 1'b0, 3'(rs1), 3'(rs2), 3'(rd), 2'b00};
    endfunction

    function automatic logic [15:0] imm_op(input int op, input int r, input int imm);
        return {4'(op), 1'b0, 3'(r), 8'(imm)};
    endfunction

    // Memory responder: programmable wait states, stray acks while idle
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            icnt  <= 0;
            dcnt  <= 0;
            itgt  <= (rand_mode != 0) ? int'($urandom_range(0, 2)) : iwait;
            dtgt  <= (rand_mode != 0) ? int'($urandom_range(0, 3)) : dwait;
            ispur <= 1'b0;
            dspur <= 1'b0;
            for (int i = 0; i < 256; i++) dmem[i] <= init_mem[i];
        end else begin
            if (imem_req && imem_ack) begin
                icnt <= 0;
                itgt <= (rand_mode != 0) ? int'($urandom_range(0, 2)) : iwait;
            end else if (imem_req) begin
                icnt <= icnt + 1;
            end
            if (dmem_req && dmem_ack) begin
                dcnt <= 0;
                dtgt <= (rand_mode != 0) ? int'($urandom_range(0, 3)) : dwait;
                if (dmem_we) dmem[dmem_addr] <= dmem_wdata;
            end else if (dmem_req) begin
                dcnt <= dcnt + 1;
            end
            ispur <= (rand_mode != 0) && ($urandom_range(0, 3) == 0);
            dspur <= (rand_mode != 0) && ($urandom_range(0, 3) == 0);
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Monitor: scoreboard pops on retire, plus handshake stability checks
    initial begin
        exp_t e, pe;
        bit post = 0, ih = 0, ia = 0, dh = 0, da = 0, st_seen = 0;
        int ill = 0, st_a = 0, st_d = 0;
        logic [7:0] h_ia, h_da, h_dw;
        logic h_we;
        forever begin
            @(negedge clk);
            if (reset) begin
                post = 0; ih = 0; ia = 0; dh = 0; da = 0; st_seen = 0; ill = 0;
            end else begin
                if (post) begin
                    chk("next_pc", dbg_pc, pe.npc);
                    chk("carry", carry_flag, pe.carry);
                    post = 0;
                end
                if (ia) chk("imem_req_drop", imem_req, 1'b0);
                if (ih) begin
                    chk("imem_req_held", imem_req, 1'b1);
                    chk("imem_addr_stable", imem_addr, h_ia);
                end
                if (da) chk("dmem_req_drop", dmem_req, 1'b0);
                if (dh) begin
                    chk("dmem_req_held", dmem_req, 1'b1);
                    chk("dmem_addr_stable", dmem_addr, h_da);
                    chk("dmem_wdata_stable", dmem_wdata, h_dw);
                    chk("dmem_we_stable", dmem_we, h_we);
                end
                ih = imem_req && !imem_ack;  ia = imem_req && imem_ack;  h_ia = imem_addr;
                dh = dmem_req && !dmem_ack;  da = dmem_req && dmem_ack;
                h_da = dmem_addr;  h_dw = dmem_wdata;  h_we = dmem_we;
                if (dmem_req && dmem_ack && dmem_we) begin
                    st_seen = 1; st_a = dmem_addr; st_d = dmem_wdata;
                end
                if (illegal_op) ill++;
                if (retire) begin
                    if (exp_q.size() == 0) begin
                        chk("retire_expected", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("retire_pc", dbg_pc, e.pc);
                        chk("illegal_pulses", ill, e.ill);
                        chk("store_issued", st_seen, e.st);
                        if (e.st != 0 && st_seen) begin
                            chk("store_addr", st_a, e.addr);
                            chk("store_data", st_d, e.data);
                        end
                        if (lat_chk != 0) chk("retire_cycle", cyc, e.cyc);
                        pe = e;
                        post = 1;
                    end
                    ill = 0;
                    st_seen = 0;
                end
            end
        end
    end

    // Reset, predict n retirements with the ISA model, release and drain
    task automatic run(input int n, input int budget);
        int rf[8];
        int mem[256];
        int pc, c, cum, lat, op, a, b, r;
        logic [15:0] ins;
        exp_t e;
        reset = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 256; i++) begin
            init_mem[i] = 8'($urandom);
            mem[i] = init_mem[i];
        end
        for (int i = 0; i < 8; i++) rf[i] = 0;
        pc = 0; c = 0; cum = 0;
        for (int k = 0; k < n; k++) begin
            ins = imem[pc];
            op  = int'(ins[15:12]);
            a   = rf[ins[10:8]];
            b   = rf[ins[7:5]];
            if (op == 15) break;
            e.pc = pc; e.npc = (pc + 1) % 256; e.ill = 0; e.st = 0; e.addr = 0; e.data = 0;
            lat = 4;
            case (op)
                1: begin r = a + b; rf[ins[4:2]] = r % 256; c = (r > 255) ? 1 : 0; end
                2: begin rf[ins[4:2]] = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
                3: rf[ins[4:2]] = a & b;
                4: rf[ins[4:2]] = a | b;
                5: rf[ins[4:2]] = a ^ b;
                6: rf[ins[10:8]] = int'(ins[7:0]);
                7: begin rf[ins[4:2]] = mem[a]; lat = 5 + dwait; end
                8: begin mem[a] = b; e.st = 1; e.addr = a; e.data = b; lat = 5 + dwait; end
                9: e.npc = int'(ins[7:0]);
                10: if (a == 0) e.npc = int'(ins[7:0]);
                11, 12, 13, 14: e.ill = 1;
                default: ;
            endcase
            e.carry = c;
            cum += lat;
            e.cyc = cum - 1;
            exp_q.push_back(e);
            pc = e.npc;
        end
        repeat (2) @(negedge clk);
        chk("rst_imem_req", imem_req, 1'b0);
        chk("rst_dmem_req", dmem_req, 1'b0);
        chk("rst_retire", retire, 1'b0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_pc", dbg_pc, 8'h00);
        chk("rst_carry", carry_flag, 1'b0);
        reset = 1'b0;
        #1;
        chk("first_fetch_req", imem_req, 1'b1);
        chk("first_fetch_addr", imem_addr, 8'h00);
        for (int t = 0; t < budget && exp_q.size() != 0; t++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("all_retired", exp_q.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            imem[i] = 16'h0000;
            init_mem[i] = 8'h00;
        end

        // Directed program: ALU/carry, store/load with 3 wait states, branches, PC wrap
        rand_mode = 0; iwait = 0; dwait = 3; lat_chk = 1;
        imem[0]   = imm_op(6, 1, 5);
        imem[1]   = imm_op(6, 2, 3);
        imem[2]   = enc(1, 1, 2, 3);
        imem[3]   = enc(8, 1, 3, 0);
        imem[4]   = imm_op(6, 1, 255);
        imem[5]   = imm_op(6, 2, 1);
        imem[6]   = enc(1, 1, 2, 3);
        imem[7]   = enc(8, 2, 3, 0);
        imem[8]   = enc(2, 2, 1, 4);
        imem[9]   = enc(8, 2, 4, 0);
        imem[10]  = imm_op(6, 1, 16);
        imem[11]  = imm_op(6, 2, 171);
        imem[12]  = enc(8, 1, 2, 0);
        imem[13]  = enc(7, 1, 0, 5);
        imem[14]  = enc(8, 0, 5, 0);
        imem[15]  = imm_op(10, 0, 32);
        imem[32]  = imm_op(6, 1, 1);
        imem[33]  = imm_op(10, 1, 64);
        imem[34]  = imm_op(9, 0, 254);
        run(22, 400);

        // Reset asserted while a store waits for dmem_ack
        for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
        imem[0] = imm_op(6, 1, 8'h33);
        imem[1] = enc(8, 1, 1, 0);
        dwait = 200; lat_chk = 0;
        run(1, 50);
        for (int t = 0; t < 20 && !dmem_req; t++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("mem_wait_req", dmem_req, 1'b1);
        chk("mem_wait_ack", dmem_ack, 1'b0);
        reset = 1'b1;
        #1;
        chk("reset_drops_dmem_req", dmem_req, 1'b0);
        chk("reset_drops_imem_req", imem_req, 1'b0);
        chk("reset_clears_pc", dbg_pc, 8'h00);

        // Random program with random wait states and stray acks
        for (int i = 0; i < 256; i++) imem[i] = {4'($urandom_range(0, 14)), 12'($urandom)};
        imem[0] = enc(8, 1, 1, 0);
        rand_mode = 1; dwait = 0;
        run(300, 20000);

        // Illegal opcode then HALT
        rand_mode = 0; iwait = 0; dwait = 0; lat_chk = 1;
        for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
        imem[0] = 16'hB123;
        imem[1] = 16'hF000;
        run(4, 100);
        for (int t = 0; t < 20 && !halted; t++) @(negedge clk);
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            chk("halted", halted, 1'b1);
            chk("halt_no_fetch", imem_req, 1'b0);
            chk("halt_no_retire", retire, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

endmodule
